// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO write- and read-side controllers.
//   DEFAULT_ADDRSIZE : default address width (FIFO depth = 2**ADDRSIZE)
//   bin2gray()       : binary -> reflected Gray code
//   gray2bin()       : reflected Gray code -> binary
// Both functions work on zero-extended 32-bit values. Any pointer up to 32
// bits converts correctly because the unused upper bits stay zero. Callers
// size the result back with a cast.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_ADDRSIZE = 6;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Prefix XOR from the MSB downwards, built in log2(32) doubling steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    bin = bin ^ (bin >> 1);
    bin = bin ^ (bin >> 2);
    bin = bin ^ (bin >> 4);
    bin = bin ^ (bin >> 8);
    bin = bin ^ (bin >> 16);
    return bin;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl_if
// Write-side FIFO control bundle between the write-domain client/fifo_mem and
// wptr_full_ctrl.
//   winc         : write request for the current cycle
//   rptr         : Gray read pointer from the read domain (asynchronous)
//   ovf_clr      : clears woverflow
//   wclken       : write enable to fifo_mem (combinational)
//   waddr        : memory write address
//   wptr         : registered Gray write pointer, sent to the read domain
//   wfull        : registered full flag
//   walmost_full : registered almost-full flag
//   wlevel       : registered, pessimistic fill level
//   woverflow    : sticky write-while-full flag
// The master modport is the client side and the slave modport is the controller.
// -----------------------------------------------------------------------------
interface wptr_full_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = DEFAULT_ADDRSIZE
);

  logic                winc;
  logic [ADDRSIZE:0]   rptr;
  logic                ovf_clr;
  logic                wclken;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, rptr, ovf_clr,
    input  wclken, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, rptr, ovf_clr,
    output wclken, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

endinterface

// File: rtl/sync_r2w.sv
// -----------------------------------------------------------------------------
// sync_r2w
// Two-flop synchroniser that brings a Gray-coded read pointer into wclk. A
// change on d is visible on q after two rising wclk edges.
//   wclk   : destination clock
//   wrst_n : asynchronous active-low reset (clears both stages)
//   d      : asynchronous input (Gray code, so only one bit changes at a time)
//   q      : synchronised output
// -----------------------------------------------------------------------------
module sync_r2w #(
  parameter int WIDTH = 7
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments are required here. With blocking
  // assignments, q would take the new meta value in the same edge and the
  // two stages would collapse into one.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
// Write-domain pointer and status controller for the asynchronous FIFO.
// It keeps the binary and Gray write pointers and synchronises the read
// pointer into wclk. From these it derives full, almost-full, the fill level
// and a sticky overflow flag.
//   wclk   : write-domain clock
//   wrst_n : asynchronous active-low reset
//   bus    : wptr_full_ctrl_if.slave (winc, rptr, ovf_clr in;
//            wclken, waddr, wptr, wfull, walmost_full, wlevel, woverflow out)
// Every status output is registered except wclken (= winc & ~wfull). A write
// accepted at an edge lands at the current waddr, and waddr advances at the
// same edge.
// -----------------------------------------------------------------------------
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = DEFAULT_ADDRSIZE,
  parameter int AFULL_THRESH = 56
) (
  input  logic                wclk,
  input  logic                wrst_n,
  wptr_full_ctrl_if.slave     bus
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wptr_q;
  logic          wfull_q;
  logic          walmost_full_q;
  logic [PW-1:0] wlevel_q;
  logic          woverflow_q;

  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] rbin;
  logic          push;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] wlevel_next;
  logic          wfull_next;
  logic          walmost_full_next;
  logic          woverflow_next;

  sync_r2w #(.WIDTH(PW)) u_sync_r2w (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d      (bus.rptr),
    .q      (wq2_rptr)
  );

  // NOTE: every signal gets a default at the top of the block. Any path that
  // left a signal unassigned would infer a latch.
  always_comb begin
    push              = bus.winc & ~wfull_q;
    wbin_next         = wbin + PW'(push);
    wgray_next        = PW'(bin2gray(32'(wbin_next)));
    rbin              = PW'(gray2bin(32'(wq2_rptr)));
    // Modular subtraction gives the correct distance across pointer wrap.
    // rbin lags the true read pointer, so the level is never underestimated.
    wlevel_next       = wbin_next - rbin;
    walmost_full_next = (wlevel_next >= AFULL_LVL);
    // The FIFO is full when the Gray pointers differ only in their two MSBs,
    // which means the write pointer is exactly one lap ahead of the read pointer.
    wfull_next        = (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                        wq2_rptr[ADDRSIZE-2:0]});
    // A set takes priority over a clear in the same cycle.
    woverflow_next    = woverflow_q;
    if (bus.winc && wfull_q) begin
      woverflow_next = 1'b1;
    end else if (bus.ovf_clr) begin
      woverflow_next = 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin           <= wbin_next;
      wptr_q         <= wgray_next;
      wfull_q        <= wfull_next;
      walmost_full_q <= walmost_full_next;
      wlevel_q       <= wlevel_next;
      woverflow_q    <= woverflow_next;
    end
  end

  assign bus.wclken       = push;
  assign bus.waddr        = wbin[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
// Directed bench for wptr_full_ctrl (ADDRSIZE=6, AFULL_THRESH=56). It covers
// reset, fill, almost-full, overflow, release from full and wrap-around. The
// overflow/release sequence is a table of per-cycle input/expectation records.
// -----------------------------------------------------------------------------
module tb_wptr_full_ctrl;

  logic wclk;
  logic wrst_n;
  int   checks;
  int   failures;

  wptr_full_ctrl_if #(.ADDRSIZE(6)) bus ();

  wptr_full_ctrl #(
    .ADDRSIZE     (6),
    .AFULL_THRESH (56)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic       ovf_clr;
    logic [6:0] rptr;
    logic [5:0] waddr;
    logic [6:0] wptr;
    logic       wfull;
    logic [6:0] wlevel;
    logic       walmost_full;
    logic       woverflow;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [6:0] to_gray(input int n);
    logic [6:0] b;
    b = 7'(n);
    return (b >> 1) ^ b;
  endfunction

  task automatic do_reset();
    wrst_n      = 1'b0;
    bus.winc    = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.rptr    = '0;
    repeat (3) step();
    wrst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wrst_n      = 1'b0;
    bus.winc    = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.rptr    = '0;

    // Overflow/release table, applied starting from a full FIFO (wbin=64).
    //         winc clr  rptr        waddr wptr        full lvl af ovf
    vecs[0] = '{1'b1, 1'b0, 7'b0000000, 6'd0, 7'b1100000, 1'b1, 7'd64, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 7'b0000000, 6'd0, 7'b1100000, 1'b1, 7'd64, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 7'b0000000, 6'd0, 7'b1100000, 1'b1, 7'd64, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 7'b0000001, 6'd0, 7'b1100000, 1'b1, 7'd64, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 7'b0000001, 6'd0, 7'b1100000, 1'b1, 7'd64, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 7'b0000001, 6'd0, 7'b1100000, 1'b0, 7'd63, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 7'b0000001, 6'd1, 7'b1100001, 1'b1, 7'd64, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 7'b0000001, 6'd1, 7'b1100001, 1'b1, 7'd64, 1'b1, 1'b0};

    // Reset state while wrst_n is held low.
    #2;
    check("rst_waddr", 32'(bus.waddr), 0);
    check("rst_wptr", 32'(bus.wptr), 0);
    check("rst_wfull", 32'(bus.wfull), 0);
    check("rst_wlevel", 32'(bus.wlevel), 0);
    check("rst_woverflow", 32'(bus.woverflow), 0);
    check("rst_walmost_full", 32'(bus.walmost_full), 0);
    do_reset();

    // Ten writes, then an asynchronous reset in the middle of a cycle.
    bus.winc = 1'b1;
    repeat (10) step();
    check("pre_rst_waddr", 32'(bus.waddr), 10);
    check("pre_rst_wlevel", 32'(bus.wlevel), 10);
    #2;
    wrst_n = 1'b0;
    #1;
    check("async_rst_waddr", 32'(bus.waddr), 0);
    check("async_rst_wptr", 32'(bus.wptr), 0);
    check("async_rst_wfull", 32'(bus.wfull), 0);
    check("async_rst_wlevel", 32'(bus.wlevel), 0);
    check("async_rst_woverflow", 32'(bus.woverflow), 0);
    check("async_rst_wclken", 32'(bus.wclken), 1);
    do_reset();

    // Fill from empty: almost-full at 56, full on the edge accepting write 64.
    bus.winc = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      check("fill_waddr", 32'(bus.waddr), 32'(i % 64));
      check("fill_wlevel", 32'(bus.wlevel), 32'(i));
      check("fill_walmost_full", 32'(bus.walmost_full), (i >= 56) ? 1 : 0);
      check("fill_wfull", 32'(bus.wfull), (i == 64) ? 1 : 0);
    end
    check("full_wptr", 32'(bus.wptr), 32'(7'b1100000));
    check("full_wclken", 32'(bus.wclken), 0);
    bus.winc = 1'b0;

    // Overflow, clear priority and release from full.
    for (int v = 0; v < 8; v++) begin
      bus.winc    = vecs[v].winc;
      bus.ovf_clr = vecs[v].ovf_clr;
      bus.rptr    = vecs[v].rptr;
      step();
      check($sformatf("vec%0d_waddr", v), 32'(bus.waddr), 32'(vecs[v].waddr));
      check($sformatf("vec%0d_wptr", v), 32'(bus.wptr), 32'(vecs[v].wptr));
      check($sformatf("vec%0d_wfull", v), 32'(bus.wfull), 32'(vecs[v].wfull));
      check($sformatf("vec%0d_wlevel", v), 32'(bus.wlevel), 32'(vecs[v].wlevel));
      check($sformatf("vec%0d_walmost_full", v), 32'(bus.walmost_full),
            32'(vecs[v].walmost_full));
      check($sformatf("vec%0d_woverflow", v), 32'(bus.woverflow), 32'(vecs[v].woverflow));
    end
    bus.ovf_clr = 1'b0;
    do_reset();

    // Wrap: 200 writes while the reader keeps up; the level stays small.
    bus.winc = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      step();
      check("wrap_waddr", 32'(bus.waddr), 32'(n % 64));
      check("wrap_wptr_msb", 32'(bus.wptr[6]), 32'((n / 64) % 2));
      check("wrap_wfull", 32'(bus.wfull), 0);
      check("wrap_level_lt8", 32'(bus.wlevel < 7'd8), 1);
      bus.rptr = to_gray(n);
    end
    bus.winc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and status controller for the asynchronous FIFO. It sits directly upstream of fifo_mem, driving its waddr, wclken and wfull. It also exports the Gray-coded write pointer for the read-domain synchroniser. It synchronises the read pointer into wclk and produces full, almost-full, fill level and a sticky overflow flag.

Parameters:
ADDRSIZE, 6, address width; FIFO depth = 2^ADDRSIZE; must match fifo_mem.
AFULL_THRESH, 56, fill level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.

Ports:
wclk  input  1  write-domain clock; all state updates on its rising edge.
wrst_n  input  1  asynchronous active-low reset.
winc  input  1  write request for the current cycle.
rptr  input  ADDRSIZE+1  Gray-coded read pointer from the read domain; asynchronous to wclk.
ovf_clr  input  1  clears woverflow.
wclken  output  1  write enable to fifo_mem; equals winc & ~wfull, combinational.
waddr  output  ADDRSIZE  memory write address; lower ADDRSIZE bits of the binary pointer.
wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
wfull  output  1  registered full flag.
walmost_full  output  1  registered; high when fill level >= AFULL_THRESH.
wlevel  output  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE, pessimistic.
woverflow  output  1  sticky flag; a write was attempted while full.

Behaviour:
- Reset (asynchronous, wrst_n=0) clears all of the following; they hold while reset is asserted:
  - binary pointer wbin, wptr, synchroniser flops;
  - wfull, walmost_full, wlevel, woverflow (all 0);
  - waddr=0, and therefore wclken=winc.
- Reset mid-operation: pointers are discarded immediately and memory contents are don't-care. The read side must be reset together with this block.
- Accept condition: push = winc & ~wfull. wbinnext = wbin + push, modulo 2^(ADDRSIZE+1). wgraynext = (wbinnext>>1) ^ wbinnext. Both registered each edge.
- Write latency: data presented with push is written at the same edge; waddr advances at that edge.
- Synchroniser: 2 flops on rptr -> wq2_rptr. An rptr change is visible in wq2_rptr after 2 edges.
- Full: wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}), registered.
  - wfull asserts on the same edge that accepts the write that fills the FIFO. No further write is accepted.
  - wfull deasserts on the 3rd wclk edge after rptr changes.
  - wfull is conservative: it may stay high while space exists, but must never be low while the FIFO is full.
- Level: rbin = gray2bin(wq2_rptr); wlevel_next = wbinnext - rbin in ADDRSIZE+1-bit arithmetic (modular subtraction handles wrap); registered. walmost_full_next = (wlevel_next >= AFULL_THRESH).
- Overflow: set when winc & wfull; cleared when ovf_clr & ~(winc & wfull). A simultaneous set and clear leaves the flag set.
- Wrap-around: the pointer MSB toggles every 2^ADDRSIZE writes; waddr wraps from 2^ADDRSIZE-1 to 0 with no bubble.
- winc held high while full: the pointer holds and woverflow sets.
- winc with rptr changing in the same cycle: the write is accepted against the stale wq2_rptr only if wfull=0.

Decomposition:
- Shared package/include fifo_pkg holds:
  - default ADDRSIZE;
  - bin2gray and gray2bin functions, parameterised on width, reused by the read-side controller.
- Sub-module sync_r2w: parameterised-width 2-flop synchroniser with async active-low reset. It is instantiated once here and mirrored as sync_w2r on the read side.

Test Plan:
- Reset: assert wrst_n=0 mid-stream after 10 writes -> waddr=0, wptr=0, wfull=0, wlevel=0, woverflow=0 immediately, without waiting for a clock edge.
- Fill: rptr=0, 64 consecutive winc -> wfull=1 on the edge accepting the 64th write; waddr=0, wptr=7'b1100000, wlevel=64; wclken=0 afterwards.
- Overflow: while full, winc=1 for 1 cycle -> wptr unchanged, woverflow=1. Then ovf_clr=1 alone -> woverflow=0. Then ovf_clr=1 together with winc=1 -> woverflow=1.
- Almost-full: 55 writes -> walmost_full=0, wlevel=55. 56th write -> walmost_full=1 on the same edge.
- Release: from full, drive rptr=7'b0000001 -> wfull stays 1 for 2 edges and goes 0 on the 3rd edge; wlevel=63 on that edge.
- Wrap: 200 writes interleaved with rptr advancing so that level stays below 8 -> wfull never asserts; wptr MSB toggles after writes 64, 128 and 192; waddr = write count mod 64 throughout.
